// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Holds the FSM state encoding, default parameter values and the width helper.
package gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg;

    typedef enum logic [1:0] {
        S_WAIT_SYNC = 2'd0,
        S_STRETCH   = 2'd1,
        S_RELEASE   = 2'd2,
        S_DONE_ST   = 2'd3
    } rstseq_state_e;

    localparam int DEF_NOUT        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STRETCH     = 16;
    localparam int DEF_GAP         = 4;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstsync.sv
// Reset deassertion synchroniser: asserts asynchronously with R, releases
// STAGES clock edges after R falls by shifting zeros through a chain of ones.
module gf180mcu_fd_sc_mcu9t5v0__rstsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic r,
    output logic sync_rst
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_rst = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Staged reset sequencer: synchronises R release, stretches it, then releases
// the active-low RNO outputs one by one with a fixed gap, raising DONE last.
module gf180mcu_fd_sc_mcu9t5v0__rstseq
    import gf180mcu_fd_sc_mcu9t5v0__rstseq_pkg::*;
#(
    parameter int NOUT        = DEF_NOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STRETCH     = DEF_STRETCH,
    parameter int GAP         = DEF_GAP
) (
    input  logic            CLK,
    input  logic            R,
    input  logic            SRST,
    output logic [NOUT-1:0] RNO,
    output logic            DONE,
    input  logic            VDD,
    input  logic            VSS
);

    localparam int MAXC = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = clog2_w(MAXC + 1);
    localparam int IW   = clog2_w(NOUT);

    localparam logic [CW-1:0] STRETCH_C = CW'(STRETCH);
    localparam logic [CW-1:0] GAP_C     = CW'(GAP);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NOUT - 1);

    rstseq_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NOUT-1:0] rno_q, rno_d;
    logic            done_q, done_d;
    logic            go_first;
    logic            sync_rst;
    logic            unused_pwr;

    assign unused_pwr = VDD ^ VSS;

    gf180mcu_fd_sc_mcu9t5v0__rstsync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (CLK),
        .r        (R),
        .sync_rst (sync_rst)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rno_d    = rno_q;
        done_d   = done_q;
        go_first = 1'b0;
        cnt_inc  = cnt_q + 1'b1;

        case (state_q)
            // The edge that leaves WAIT_SYNC is already the first stretch edge,
            // which places RNO[0] at edge SYNC_STAGES+STRETCH.
            S_WAIT_SYNC: begin
                if (!sync_rst) begin
                    if (STRETCH_C == CW'(1)) begin
                        go_first = 1'b1;
                    end else begin
                        state_d = S_STRETCH;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_STRETCH: begin
                if (cnt_inc == STRETCH_C) begin
                    go_first = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                if (cnt_inc == GAP_C) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int i = 0; i < NOUT; i++) begin
                        if (idx_q == IW'(i)) begin
                            rno_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE_ST;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE_ST: begin
                rno_d  = '1;
                done_d = 1'b1;
            end
            default: begin
                state_d = S_WAIT_SYNC;
            end
        endcase

        if (go_first) begin
            rno_d[0] = 1'b1;
            cnt_d    = '0;
            if (NOUT == 1) begin
                state_d = S_DONE_ST;
                done_d  = 1'b1;
            end else begin
                state_d = S_RELEASE;
                idx_d   = IW'(1);
            end
        end

        // Software restart skips the synchroniser; ignored until it has released.
        if (SRST && (state_q != S_WAIT_SYNC)) begin
            state_d = S_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rno_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= S_WAIT_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rno_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rno_q   <= rno_d;
            done_q  <= done_d;
        end
    end

    assign RNO  = rno_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Scoreboard bench for the staged reset sequencer: expected {DONE,RNO} per edge
// is derived from the release schedule (RNO[i] at s+i*GAP, DONE with the last bit).
module tb_gf180mcu_fd_sc_mcu9t5v0__rstseq;

    logic       CLK;
    logic       R;
    logic       SRST;
    logic [3:0] RNO;
    logic       DONE;
    logic       R_b;
    logic       SRST_b;
    logic [0:0] RNO_b;
    logic       DONE_b;
    logic       VDD;
    logic       VSS;

    int n_cmp;
    int n_err;
    int edge_n;
    int s_a;

    logic [4:0] exp_q[$];
    logic [1:0] exp_b_q[$];

    gf180mcu_fd_sc_mcu9t5v0__rstseq dut_a (
        .CLK  (CLK),
        .R    (R),
        .SRST (SRST),
        .RNO  (RNO),
        .DONE (DONE),
        .VDD  (VDD),
        .VSS  (VSS)
    );

    gf180mcu_fd_sc_mcu9t5v0__rstseq #(
        .NOUT        (1),
        .SYNC_STAGES (3),
        .STRETCH     (1),
        .GAP         (1)
    ) dut_b (
        .CLK  (CLK),
        .R    (R_b),
        .SRST (SRST_b),
        .RNO  (RNO_b),
        .DONE (DONE_b),
        .VDD  (VDD),
        .VSS  (VSS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Default config: RNO[i] rises at s + 4*i, DONE with RNO[3].
    function automatic logic [4:0] exp_a(input int k, input int s);
        logic [4:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (k >= s + 4 * i) v[i] = 1'b1;
        end
        if (k >= s + 12) v[4] = 1'b1;
        return v;
    endfunction

    task automatic step_a(input string tag);
        edge_n++;
        exp_q.push_back(exp_a(edge_n, s_a));
        @(posedge CLK);
        #1;
        check_val($sformatf("%s@%0d", tag, edge_n), {27'd0, DONE, RNO}, {27'd0, exp_q.pop_front()});
    endtask

    task automatic run_to_a(input string tag, input int last);
        while (edge_n < last) step_a(tag);
    endtask

    // Apply R mid-cycle, confirm the clear needs no clock edge, release on a falling edge.
    task automatic reset_a(input string tag, input int hold);
        R = 1'b1;
        #1;
        check_val({tag, "_clr"}, {27'd0, DONE, RNO}, 32'd0);
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        R = 1'b0;
        edge_n = 0;
        s_a = 18;
    endtask

    always @(negedge CLK) begin
        logic bad;
        bad = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (RNO[i] && !RNO[i-1]) bad = 1'b1;
        end
        assert (!bad) else begin
            $error("FAIL monotonic RNO=%b", RNO);
            n_err++;
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        edge_n = 0;
        s_a    = 18;
        VDD    = 1'b1;
        VSS    = 1'b0;
        R      = 1'b1;
        SRST   = 1'b0;
        R_b    = 1'b1;
        SRST_b = 1'b0;

        // Power-on
        repeat (3) @(posedge CLK);
        #1;
        check_val("por_a", {27'd0, DONE, RNO}, 32'd0);
        check_val("por_b", {30'd0, DONE_b, RNO_b}, 32'd0);
        @(negedge CLK);
        R = 1'b0;
        run_to_a("pwr", 32);

        // One-cycle SRST at edge 40 after DONE
        run_to_a("pre_srst", 39);
        SRST = 1'b1;
        s_a  = 40 + 16;
        step_a("srst");
        SRST = 1'b0;
        run_to_a("srst_seq", 70);

        // R pulsed mid-cycle after edge 24
        reset_a("r_seq", 2);
        run_to_a("r_pre", 24);
        #1;
        R = 1'b1;
        #1;
        check_val("r_async", {27'd0, DONE, RNO}, 32'd0);
        #1;
        R = 1'b0;
        edge_n = 0;
        s_a = 18;
        run_to_a("r_post", 20);

        // SRST held for edges 40-45
        run_to_a("hold_pre", 39);
        SRST = 1'b1;
        while (edge_n < 45) begin
            s_a = edge_n + 1 + 16;
            step_a("hold");
        end
        SRST = 1'b0;
        run_to_a("hold_seq", 74);

        // SRST during R and WAIT_SYNC is ignored
        SRST = 1'b1;
        reset_a("ws", 3);
        step_a("ws_srst");
        step_a("ws_srst");
        SRST = 1'b0;
        run_to_a("ws_seq", 32);

        // Minimal config instance
        @(negedge CLK);
        R_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            exp_b_q.push_back((k >= 4) ? 2'b11 : 2'b00);
            @(posedge CLK);
            #1;
            check_val($sformatf("min@%0d", k), {30'd0, DONE_b, RNO_b}, {30'd0, exp_b_q.pop_front()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
